// File: rtl/axi_default_slave_r.sv
// Read-channel default slave: accepts AR transfers that decode to no mapped
// slave, answers with ARLEN+1 DECERR beats and records the faulting address.
module axi_default_slave_r #(
   parameter int ID_BITS   = 8,
   parameter int LEN_BITS  = 4,
   parameter int DATA_BITS = 32,
   parameter int CNT_BITS  = 8
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   input  logic                 ARVALID_DS,
   input  logic [ID_BITS-1:0]   ARID_DS,
   input  logic [31:0]          ARADDR_DS,
   input  logic [LEN_BITS-1:0]  ARLEN_DS,
   output logic                 ARREADY_DS,
   output logic [ID_BITS-1:0]   RID_DS,
   output logic [DATA_BITS-1:0] RDATA_DS,
   output logic [1:0]           RRESP_DS,
   output logic                 RLAST_DS,
   output logic                 RVALID_DS,
   input  logic                 RREADY_DS,
   output logic [31:0]          ERR_ADDR,
   output logic [CNT_BITS-1:0]  ERR_CNT
);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t              state_q, state_d;
   logic [ID_BITS-1:0]  rid_q, rid_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [LEN_BITS-1:0] beat_q, beat_d;
   logic [31:0]         errAddr_q, errAddr_d;
   logic [CNT_BITS-1:0] errCnt_q, errCnt_d;

   logic arHandshake;
   logic rHandshake;
   logic lastBeat;

   // Every output is a decode of registered state, so no input reaches an output.
   assign lastBeat    = (beat_q == len_q);
   assign ARREADY_DS  = (state_q == IDLE);
   assign RVALID_DS   = (state_q == BURST);
   assign RLAST_DS    = (state_q == BURST) && lastBeat;
   assign RID_DS      = (state_q == BURST) ? rid_q : '0;
   assign RRESP_DS    = (state_q == BURST) ? 2'b11 : 2'b00;
   assign RDATA_DS    = '0;
   assign ERR_ADDR    = errAddr_q;
   assign ERR_CNT     = errCnt_q;

   assign arHandshake = ARVALID_DS && ARREADY_DS;
   assign rHandshake  = RVALID_DS && RREADY_DS;

   always_comb begin
      state_d   = state_q;
      rid_d     = rid_q;
      len_d     = len_q;
      beat_d    = beat_q;
      errAddr_d = errAddr_q;
      errCnt_d  = errCnt_q;
      case (state_q)
         IDLE: begin
            if (arHandshake) begin
               rid_d     = ARID_DS;
               len_d     = ARLEN_DS;
               beat_d    = '0;
               errAddr_d = ARADDR_DS;
               // Counter sticks at all-ones so a flood of bad accesses stays visible.
               if (errCnt_q != '1) begin
                  errCnt_d = errCnt_q + 1'b1;
               end
               state_d   = BURST;
            end
         end
         BURST: begin
            if (rHandshake) begin
               if (lastBeat) begin
                  state_d = IDLE;
               end else begin
                  beat_d  = beat_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         rid_q     <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         errAddr_q <= '0;
         errCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         rid_q     <= rid_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         errAddr_q <= errAddr_d;
         errCnt_q  <= errCnt_d;
      end
   end

endmodule

// File: doc/axi_default_slave_r.md
# axi_default_slave_r

Read-channel default slave for the projR AXI interconnect. It sits directly downstream of the read-address decoder and consumes the decoder's default-slave valid, which fires when an AR address hits no mapped slave (ROM, IM, DM, CNN, DRAM, S6). It accepts the orphaned AR transfer, returns `ARLEN+1` read beats with `RRESP=DECERR` so the issuing master never hangs, and latches the faulting address and a saturating error count for debug.

## Interface
Parameters:
- `ID_BITS`, 8, width of ARID/RID (interconnect-extended ID).
- `LEN_BITS`, 4, width of ARLEN (bursts of 1..16 beats).
- `DATA_BITS`, 32, width of RDATA.
- `CNT_BITS`, 8, width of the decode-error counter.

Ports:
- `ACLK`  in  1  clock; all state updates on the rising edge.
- `ARESETn`  in  1  reset, asynchronous, active-low.
- `ARVALID_DS`  in  1  decoder's default-slave valid (`VALID_SS[6]` after arbitration).
- `ARID_DS`  in  `ID_BITS`  AR ID.
- `ARADDR_DS`  in  32  AR address.
- `ARLEN_DS`  in  `LEN_BITS`  burst length minus 1.
- `ARREADY_DS`  out  1  AR accept.
- `RID_DS`  out  `ID_BITS`  returned ID.
- `RDATA_DS`  out  `DATA_BITS`  always 0.
- `RRESP_DS`  out  2  always `2'b11` (DECERR) while `RVALID_DS`=1; 0 otherwise.
- `RLAST_DS`  out  1  final beat flag.
- `RVALID_DS`  out  1  R beat valid.
- `RREADY_DS`  in  1  master R accept.
- `ERR_ADDR`  out  32  address of the most recent accepted AR.
- `ERR_CNT`  out  `CNT_BITS`  count of accepted ARs, saturating.

## Operation
- Two-state FSM: `IDLE`, `BURST`. Reset state is `IDLE`.
- `IDLE`: `ARREADY_DS`=1, `RVALID_DS`=0. On `ARVALID_DS & ARREADY_DS`:
  - capture `ARID_DS` into `rid_q`, `ARLEN_DS` into `len_q`, and `ARADDR_DS` into `ERR_ADDR`;
  - clear `beat_q`;
  - increment `ERR_CNT` unless it equals all-ones;
  - go to `BURST`.
- `BURST`: `ARREADY_DS`=0, `RVALID_DS`=1, `RID_DS`=`rid_q`, `RDATA_DS`=0, `RRESP_DS`=`2'b11`, `RLAST_DS`=(`beat_q`==`len_q`).
  - On `RVALID_DS & RREADY_DS` with `RLAST_DS`=0: `beat_q` increments.
  - On `RVALID_DS & RREADY_DS` with `RLAST_DS`=1: go to `IDLE`.
  - With `RREADY_DS`=0: all R outputs hold stable (AXI valid-stability rule).
- `beat_q` has width `LEN_BITS` and never wraps, because the burst ends at `beat_q`==`len_q`. `ARLEN`=15 gives 16 beats.
- `ARID_DS`, `ARADDR_DS`, `ARLEN_DS` are ignored when `ARVALID_DS`=0 or in `BURST`.
- Only one outstanding transaction. A second AR is back-pressured by `ARREADY_DS`=0 until the burst completes.
- `ERR_ADDR` and `ERR_CNT` are cleared only by reset. `ERR_CNT` saturates at `2^CNT_BITS-1`.

## Timing
- Reset values, asserted asynchronously while `ARESETn`=0:
  - state `IDLE`, so `ARREADY_DS`=1;
  - `RVALID_DS`=0, `RLAST_DS`=0, `RID_DS`=0, `RDATA_DS`=0, `RRESP_DS`=0;
  - `ERR_ADDR`=0, `ERR_CNT`=0;
  - `rid_q`, `len_q`, `beat_q` all 0.
- `ARREADY_DS`, `RVALID_DS`, `RLAST_DS`, `RRESP_DS` and `RID_DS` are decoded from registered state only. No combinational path from any input to any output.
- Latency: if the AR handshake occurs at edge k, the first R beat is valid in the cycle after edge k.
- An N-beat burst with `RREADY_DS` held high occupies exactly N cycles of `RVALID_DS`=1.
- `ARREADY_DS` returns to 1 the cycle after the last-beat handshake. Minimum AR-to-AR spacing is N+1 cycles.
- Reset mid-burst: outputs go to reset values immediately. The master sees the burst aborted; no partial state survives.
- `ERR_ADDR` and `ERR_CNT` update on the same edge as the AR handshake and are visible the following cycle.

## Test plan
- Reset release, `ARVALID_DS`=0 for 10 cycles -> `ARREADY_DS`=1, `RVALID_DS`=0, `ERR_CNT`=0 throughout.
- Single beat: AR with `ARID`=8'h25, `ARADDR`=32'h3000_0000, `ARLEN`=0, `RREADY_DS`=1 -> one cycle later `RVALID_DS`=1, `RLAST_DS`=1, `RID_DS`=8'h25, `RRESP_DS`=2'b11, `RDATA_DS`=0. Then `ERR_ADDR`=32'h3000_0000, `ERR_CNT`=1, and `ARREADY_DS`=1 the next cycle.
- Burst with backpressure: `ARLEN`=15, `RREADY_DS` toggled 1,0,1,0,... -> exactly 16 accepted beats, `RLAST_DS` only on the 16th, and R outputs stable during every `RREADY_DS`=0 cycle.
- Back-to-back: second `ARVALID_DS` held high during a 4-beat burst -> `ARREADY_DS`=0 until the 4th beat completes; the second AR is accepted the cycle after and its `RID_DS` matches.
- Mid-burst reset: drop `ARESETn` on beat 3 of 8 -> `RVALID_DS`=0, `ARREADY_DS`=1, `ERR_CNT`=0 immediately. A fresh AR after release completes normally.
- Saturation with `CNT_BITS`=2: five single-beat ARs -> `ERR_CNT` sequence 1,2,3,3,3.
